// File: rtl/aes128_dec_key_sequencer_pkg.sv
// Shared constants and types for the AES-128 decryption key sequencer:
// ALU opcodes, round constants and the sequencer state encoding.
package aes128_dec_key_sequencer_pkg;

  localparam int NROUNDS = 10;

  localparam logic [4:0] OP_DEC  = 5'h13;
  localparam logic [4:0] OP_DECF = 5'h14;
  localparam logic [4:0] OP_XORE = 5'h15;

  typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} state_t;

  // Round constant for expansion round r (1..10); other indices never used.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1B;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes128_dec_key_sequencer_sbox.sv
// Combinational forward AES S-box, one byte in and one byte out.
module aes128_dec_key_sequencer_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Row r of the table holds S(16r .. 16r+15), byte 0 in the most significant position.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/aes128_dec_key_sequencer.sv
// Expands a cipher key into the AES-128 round keys and streams them, last key
// first, as (op, round key) beats to the 128-bit ALU for inverse rounds.
module aes128_dec_key_sequencer
  import aes128_dec_key_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_ready,
  output logic         keys_valid,
  input  logic         start,
  input  logic         stall,
  output logic         busy,
  output logic [4:0]   op_out,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic         rk_last
);

  localparam logic [3:0] LAST = 4'(NROUNDS);
  localparam logic [3:0] DONE = 4'(NROUNDS + 1);

  state_t       state;
  logic [127:0] rk [0:NROUNDS];
  logic [3:0]   r;
  logic [3:0]   beat;

  logic [127:0] prev, next_rk;
  logic [31:0]  rot, sub, w0, w1, w2, w3;
  logic [4:0]   pend_op;
  logic [127:0] pend_rk;

  // One key-schedule round per cycle, always derived from the previously stored key.
  assign prev = rk[r - 4'd1];
  assign rot  = {prev[23:0], prev[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes128_dec_key_sequencer_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .y (sub[8*i +: 8])
    );
  end

  assign w0      = prev[127:96] ^ sub ^ {rcon(r), 24'h0};
  assign w1      = prev[95:64] ^ w0;
  assign w2      = prev[63:32] ^ w1;
  assign w3      = prev[31:0]  ^ w2;
  assign next_rk = {w0, w1, w2, w3};

  // beat is the index of the next beat to hand to the ALU; it walks the store backwards.
  always_comb begin
    pend_op = OP_DEC;
    if (beat == 4'd0)
      pend_op = OP_DECF;
    else if (beat == LAST)
      pend_op = OP_XORE;
  end

  assign pend_rk = rk[LAST - beat];

  assign key_ready  = (state == IDLE)   || (state == READY);
  assign keys_valid = (state == READY)  || (state == STREAM);
  assign busy       = (state == EXPAND) || (state == STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r        <= 4'd0;
      beat     <= 4'd0;
      op_out   <= 5'h00;
      rk_out   <= '0;
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      for (int i = 0; i <= NROUNDS; i++) rk[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            rk[0] <= key_in;
            r     <= 4'd1;
            state <= EXPAND;
          end
        end
        EXPAND: begin
          rk[r] <= next_rk;
          if (r == LAST) begin
            r     <= 4'd0;
            state <= READY;
          end else begin
            r <= r + 4'd1;
          end
        end
        READY: begin
          if (key_load) begin
            rk[0] <= key_in;
            r     <= 4'd1;
            state <= EXPAND;
          end else if (start) begin
            op_out   <= OP_DECF;
            rk_out   <= rk[LAST];
            rk_valid <= 1'b1;
            rk_last  <= 1'b0;
            beat     <= 4'd1;
            state    <= STREAM;
          end
        end
        STREAM: begin
          // A stalled cycle still presents the pending beat, just without rk_valid.
          if (beat == DONE) begin
            op_out   <= 5'h00;
            rk_out   <= '0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            beat     <= 4'd0;
            state    <= READY;
          end else begin
            op_out   <= pend_op;
            rk_out   <= pend_rk;
            rk_valid <= !stall;
            rk_last  <= !stall && (beat == LAST);
            if (!stall) beat <= beat + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_dec_key_sequencer.sv
// Self-checking bench for aes128_dec_key_sequencer: scoreboarded beat stream
// against the known "Thats my Kung Fu" schedule plus protocol and reset scenarios.
module tb_aes128_dec_key_sequencer;

  localparam logic [4:0]   E_DEC   = 5'h13;
  localparam logic [4:0]   E_DECF  = 5'h14;
  localparam logic [4:0]   E_XORE  = 5'h15;
  localparam logic [127:0] KEY1    = 128'h5468617473206D79204B756E67204675;
  localparam logic [127:0] KEY2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic         key_ready, keys_valid, busy, rk_valid, rk_last;
  logic [4:0]   op_out;
  logic [127:0] rk_out;

  typedef struct {
    int           idx;
    logic [4:0]   op;
    logic [127:0] rk;
    logic         last;
    logic         chk;
  } beat_t;

  beat_t        sb[$];
  logic [127:0] ks [0:10];
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  aes128_dec_key_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_load   (key_load),
    .key_ready  (key_ready),
    .keys_valid (keys_valid),
    .start      (start),
    .stall      (stall),
    .busy       (busy),
    .op_out     (op_out),
    .rk_out     (rk_out),
    .rk_valid   (rk_valid),
    .rk_last    (rk_last)
  );

  // Scoreboard consumer: every valid beat must match the oldest pushed expectation.
  always @(negedge clk) begin
    beat_t e;
    if (rk_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_beat: got op=%h rk=%h, expected no beat", op_out, rk_out);
      end else begin
        e = sb.pop_front();
        vectors++;
        if ({op_out, rk_last} !== {e.op, e.last}) begin
          miscompares++;
          $display("[TB] FAIL beat%0d_op_last: got op=%h last=%b, expected op=%h last=%b",
                   e.idx, op_out, rk_last, e.op, e.last);
        end
        if (e.chk) begin
          vectors++;
          if (rk_out !== e.rk) begin
            miscompares++;
            $display("[TB] FAIL beat%0d_rk: got %h, expected %h", e.idx, rk_out, e.rk);
          end
        end
      end
    end
  end

  task automatic push_key1();
    beat_t e;
    for (int k = 0; k <= 10; k++) begin
      e.idx  = k;
      e.op   = (k == 0) ? E_DECF : ((k == 10) ? E_XORE : E_DEC);
      e.rk   = ks[10 - k];
      e.last = (k == 10);
      e.chk  = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic push_key2();
    beat_t e;
    for (int k = 0; k <= 10; k++) begin
      e.idx  = k;
      e.op   = (k == 0) ? E_DECF : ((k == 10) ? E_XORE : E_DEC);
      e.rk   = (k == 0) ? K2_RK10 : KEY2;
      e.last = (k == 10);
      e.chk  = (k == 0) || (k == 10);
      sb.push_back(e);
    end
  endtask

  // Starts a stream from a READY negedge and drives stall / key_load at chosen beat counts.
  task automatic run_stream(input int stall_at, input int stall_len, input int load_at,
                            output int got, output int gaps, output int hold_bad);
    int sdone = 0;
    bit ldone = 0;
    got = 0; gaps = 0; hold_bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 60 && got < 11; c++) begin
      if (c > 0) @(negedge clk);
      if (rk_valid === 1'b1) got++;
      else begin
        gaps++;
        if (sb.size() > 0 && sb[0].chk && {op_out, rk_out} !== {sb[0].op, sb[0].rk}) hold_bad++;
      end
      stall = 1'b0;
      if (got == stall_at && sdone < stall_len) begin
        stall = 1'b1;
        sdone++;
      end
      key_load = 1'b0;
      if (got == load_at && !ldone) begin
        key_in   = KEY2;
        key_load = 1'b1;
        ldone    = 1;
      end
    end
    stall    = 1'b0;
    key_load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({key_ready, keys_valid, busy, rk_valid, rk_last} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b, expected 10000",
               {key_ready, keys_valid, busy, rk_valid, rk_last});
    end
    vectors++;
    if ({op_out, rk_out} !== 133'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got op=%h rk=%h, expected zero", op_out, rk_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start_idle();
    int act = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) begin
      if (rk_valid === 1'b1 || busy === 1'b1) act++;
      @(negedge clk);
    end
    vectors++;
    if (act !== 0 || key_ready !== 1'b1 || keys_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_in_idle: got %0d active cycles ready=%b kv=%b, expected 0 1 0",
               act, key_ready, keys_valid);
    end
  endtask

  task automatic test_expansion();
    int cyc = 1;
    key_in   = KEY1;
    key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    vectors++;
    if ({busy, key_ready, keys_valid} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL expand_flags: got %b, expected 100", {busy, key_ready, keys_valid});
    end
    while (keys_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 11) begin
      miscompares++;
      $display("[TB] FAIL expand_latency: got %0d cycles, expected 11", cyc);
    end
    vectors++;
    if ({busy, key_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL ready_flags: got %b, expected 01", {busy, key_ready});
    end
  endtask

  task automatic test_stream_order();
    int got, gaps, hb;
    push_key1();
    run_stream(-1, 0, -1, got, gaps, hb);
    vectors++;
    if (got !== 11 || gaps !== 0) begin
      miscompares++;
      $display("[TB] FAIL stream_count: got %0d beats %0d gaps, expected 11 0", got, gaps);
    end
    @(negedge clk);
    vectors++;
    if ({rk_valid, keys_valid, busy, key_ready} !== 4'b0101 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stream_end: got flags %b pending %0d, expected 0101 0",
               {rk_valid, keys_valid, busy, key_ready}, sb.size());
    end
  endtask

  task automatic test_stall();
    int got, gaps, hb;
    push_key1();
    run_stream(4, 3, -1, got, gaps, hb);
    vectors++;
    if (got !== 11 || gaps !== 3) begin
      miscompares++;
      $display("[TB] FAIL stall_count: got %0d beats %0d gaps, expected 11 3", got, gaps);
    end
    vectors++;
    if (hb !== 0) begin
      miscompares++;
      $display("[TB] FAIL stall_hold: got %0d bad hold cycles, expected 0", hb);
    end
    @(negedge clk);
  endtask

  task automatic test_load_during_stream();
    int got, gaps, hb;
    push_key1();
    run_stream(-1, 0, 5, got, gaps, hb);
    vectors++;
    if (got !== 11 || gaps !== 0) begin
      miscompares++;
      $display("[TB] FAIL load_in_stream: got %0d beats %0d gaps, expected 11 0", got, gaps);
    end
    @(negedge clk);
    vectors++;
    if ({keys_valid, busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL load_in_stream_state: got %b, expected 10", {keys_valid, busy});
    end
  endtask

  task automatic test_back_to_back();
    int got1, got2, gaps1, gaps2, hb;
    push_key1();
    run_stream(-1, 0, -1, got1, gaps1, hb);
    @(negedge clk);
    push_key1();
    run_stream(-1, 0, -1, got2, gaps2, hb);
    vectors++;
    if (got1 + got2 !== 22 || gaps1 + gaps2 !== 0) begin
      miscompares++;
      $display("[TB] FAIL back_to_back: got %0d beats %0d gaps, expected 22 0",
               got1 + got2, gaps1 + gaps2);
    end
    @(negedge clk);
  endtask

  task automatic test_load_start_ready();
    int cyc = 1;
    int beats = 0;
    int got, gaps, hb;
    key_in   = KEY2;
    key_load = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    start    = 1'b0;
    vectors++;
    if ({busy, key_ready, keys_valid} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL load_start_flags: got %b, expected 100", {busy, key_ready, keys_valid});
    end
    while (keys_valid !== 1'b1 && cyc < 40) begin
      if (rk_valid === 1'b1) beats++;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc !== 11 || beats !== 0) begin
      miscompares++;
      $display("[TB] FAIL load_start_expand: got %0d cycles %0d beats, expected 11 0", cyc, beats);
    end
    push_key2();
    run_stream(-1, 0, -1, got, gaps, hb);
    vectors++;
    if (got !== 11 || gaps !== 0) begin
      miscompares++;
      $display("[TB] FAIL rekey_stream: got %0d beats %0d gaps, expected 11 0", got, gaps);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    int got = 0;
    int act = 0;
    push_key2();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (rk_valid === 1'b1) got++;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({key_ready, keys_valid, busy, rk_valid, rk_last, op_out, rk_out} !== {5'b10000, 133'd0}) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got flags %b op=%h rk=%h, expected 10000 zero",
               {key_ready, keys_valid, busy, rk_valid, rk_last}, op_out, rk_out);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) begin
      if (rk_valid === 1'b1 || busy === 1'b1 || keys_valid === 1'b1) act++;
      @(negedge clk);
    end
    vectors++;
    if (act !== 0) begin
      miscompares++;
      $display("[TB] FAIL start_after_reset: got %0d active cycles, expected 0", act);
    end
  endtask

  initial begin
    ks[0]  = 128'h5468617473206D79204B756E67204675;
    ks[1]  = 128'hE232FCF191129188B159E4E6D679A293;
    ks[2]  = 128'h56082007C71AB18F76435569A03AF7FA;
    ks[3]  = 128'hD2600DE7157ABC686339E901C3031EFB;
    ks[4]  = 128'hA11202C9B468BEA1D75157A01452495B;
    ks[5]  = 128'hB1293B3305418592D210D232C6429B69;
    ks[6]  = 128'hBD3DC287B87C47156A6C9527AC2E0E4E;
    ks[7]  = 128'hCC96ED1674EAAA031E863F24B2A8316A;
    ks[8]  = 128'h8E51EF21FABB4522E43D7A0656954B6C;
    ks[9]  = 128'hBFE2BF904559FAB2A16480B4F7F1CBD8;
    ks[10] = 128'h28FDDEF86DA4244ACCC0A4FE3B316F26;

    test_reset();
    test_start_idle();
    test_expansion();
    test_stream_order();
    test_stall();
    test_load_during_stream();
    test_back_to_back();
    test_load_start_ready();
    test_reset_mid_stream();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
